// File: rtl/digit_serial_adder_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package digit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DIGIT = 8;
  localparam int NUM_DIGITS    = DEFAULT_WIDTH / DEFAULT_DIGIT;

  // Counter must stay at least one bit wide, even for single-digit builds.
  function automatic int cnt_width(input int num_digits);
    return (num_digits > 1) ? $clog2(num_digits) : 1;
  endfunction

endpackage

// File: rtl/digit_serial_adder_rca_digit.sv
// One DIGIT-wide ripple-carry slice built from full_adder cells; also
// exposes the carry into its MSB so the top can derive signed overflow.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             carry_msb
);

  logic [DIGIT:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout      = carry[DIGIT];
  assign carry_msb = carry[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Multi-cycle adder/subtractor processing DIGIT bits per clock behind
// valid/ready handshakes. Define DIGIT_SERIAL_ADDER_FLAGS_EN for ovf/zero.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int NUM_DIG = WIDTH / DIGIT;
  localparam int CNT_W   = cnt_width(NUM_DIG);
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIG - 1);

  if (WIDTH % DIGIT != 0) begin : g_width_check
    $error("digit_serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] counter;

  int unsigned      base;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic [DIGIT-1:0] dig_sum;
  logic             dig_cout;
  logic             dig_carry_msb;

  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    base  = int'(counter) * DIGIT;
    dig_a = op_a[base +: DIGIT];
    dig_b = op_b[base +: DIGIT];
  end

  rca_digit #(.DIGIT(DIGIT)) u_slice (
    .a         (dig_a),
    .b         (dig_b),
    .cin       (carry),
    .sum       (dig_sum),
    .cout      (dig_cout),
    .carry_msb (dig_carry_msb)
  );

`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
  logic [WIDTH-1:0] sum_final;

  // The zero flag must see the digit being written this cycle, not the old one.
  always_comb begin
    sum_final               = sum;
    sum_final[base +: DIGIT] = dig_sum;
  end
`else
  logic unused_carry_msb;
  assign unused_carry_msb = dig_carry_msb;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  // NOTE: only flops live here (no memories), so all of them take the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      carry     <= 1'b0;
      counter   <= '0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
      ovf       <= 1'b0;
      zero      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            op_a     <= a;
            op_b     <= b ^ {WIDTH{sub}};
            carry    <= sub ? 1'b1 : cin;
            counter  <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum[base +: DIGIT] <= dig_sum;
          carry              <= dig_cout;
          counter            <= counter + 1'b1;
          if (counter == LAST_DIGIT) begin
            cout      <= dig_cout;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
            ovf       <= dig_carry_msb ^ dig_cout;
            zero      <= (sum_final == '0);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder: directed steps with a scoreboard
// queue, plus WIDTH=8 instances at DIGIT=1 and DIGIT=8.
module tb_digit_serial_adder;

  localparam int W  = 32;
  localparam int D  = 8;
  localparam int ND = W / D;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main 32/8 instance
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
  logic         ovf, zero;
`endif

  digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    ,
    .ovf       (ovf),
    .zero      (zero)
`endif
  );

  // Shared stimulus for the two 8-bit corner instances
  logic       s_in_valid, s_out_ready, s_cin, s_sub;
  logic [7:0] s_a, s_b;
  logic       s1_in_ready, s1_out_valid, s1_cout;
  logic       s8_in_ready, s8_out_valid, s8_cout;
  logic [7:0] s1_sum, s8_sum;
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
  logic       s1_ovf, s1_zero, s8_ovf, s8_zero;
`endif

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s1_in_ready),
    .a         (s_a),
    .b         (s_b),
    .cin       (s_cin),
    .sub       (s_sub),
    .out_valid (s1_out_valid),
    .out_ready (s_out_ready),
    .sum       (s1_sum),
    .cout      (s1_cout)
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    ,
    .ovf       (s1_ovf),
    .zero      (s1_zero)
`endif
  );

  digit_serial_adder #(.WIDTH(8), .DIGIT(8)) dut_d8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s8_in_ready),
    .a         (s_a),
    .b         (s_b),
    .cin       (s_cin),
    .sub       (s_sub),
    .out_valid (s8_out_valid),
    .out_ready (s_out_ready),
    .sum       (s8_sum),
    .cout      (s8_cout)
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
    ,
    .ovf       (s8_ovf),
    .zero      (s8_zero)
`endif
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  exp_t last_exp;

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fcin, input logic fsub);
    exp_t         e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = fsub ? ~fb : fb;
    full   = {1'b0, fa} + {1'b0, bb} + {{W{1'b0}}, (fsub ? 1'b1 : fcin)};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (fa[W-1] == bb[W-1]) && (e.sum[W-1] != fa[W-1]);
    e.zero = (e.sum == '0);
    return e;
  endfunction

  // Present operands, wait for acceptance, push the expectation, then scramble
  // the inputs so any late sampling shows up as a wrong result.
  task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic tcin, input logic tsub);
    int k = 0;
    a = ta; b = tb_; cin = tcin; sub = tsub;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    q.push_back(model(ta, tb_, tcin, tsub));
    a = $urandom; b = $urandom; cin = ~tcin; sub = ~tsub;
  endtask

  task automatic wait_result(input string tag);
    int lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, lat, ND);
    if (q.size() == 0) begin
      check({tag, "_scoreboard"}, 0, 1);
    end else begin
      last_exp = q.pop_front();
      check({tag, "_sum"}, sum, last_exp.sum);
      check({tag, "_cout"}, cout, last_exp.cout);
`ifdef DIGIT_SERIAL_ADDER_FLAGS_EN
      check({tag, "_ovf"}, ovf, last_exp.ovf);
      check({tag, "_zero"}, zero, last_exp.zero);
`endif
    end
  endtask

  task automatic release_result(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    logic       seen;
    int         l1, l8;
    logic [8:0] s_exp;

    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0;
    s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);

    // Reset during CALC aborts the transaction
    accept(32'd1, 32'd2, 1'b0, 1'b0);
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    q.delete();
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_sum", sum, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("midrst_no_result", seen, 1'b0);

    accept(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result("ripple");
    release_result("ripple");

    accept(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    wait_result("sovf");
    release_result("sovf");

    accept(32'd5, 32'd7, 1'b1, 1'b1);
    wait_result("borrow");
    release_result("borrow");

    for (int i = 0; i < 4; i++) begin
      accept($urandom, $urandom, 1'($urandom), 1'($urandom));
      wait_result($sformatf("rand%0d", i));
      release_result($sformatf("rand%0d", i));
    end

    // Backpressure: result holds while new operands wait at the input
    accept(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0);
    wait_result("bp_first");
    a = 32'hDEAD_BEEF; b = 32'h0000_0001; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("bp_valid%0d", i), out_valid, 1'b1);
      check($sformatf("bp_ready%0d", i), in_ready, 1'b0);
      check($sformatf("bp_sum%0d", i), sum, last_exp.sum);
      check($sformatf("bp_cout%0d", i), cout, last_exp.cout);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_idle_ready", in_ready, 1'b1);
    accept(32'hDEAD_BEEF, 32'h0000_0001, 1'b0, 1'b0);
    check("bp_accepted", in_ready, 1'b0);
    wait_result("bp_second");
    release_result("bp_second");

    // Parameter corners: WIDTH=8 with DIGIT=1 and DIGIT=8
    s_a = 8'hAA; s_b = 8'h55; s_cin = 1'b1; s_sub = 1'b0;
    s_exp = {1'b0, s_a} + {1'b0, s_b} + 9'(s_cin);
    check("corner_ready_d1", s1_in_ready, 1'b1);
    check("corner_ready_d8", s8_in_ready, 1'b1);
    s_in_valid = 1'b1;
    step();
    s_in_valid = 1'b0;
    s_a = 8'h00; s_b = 8'h00; s_cin = 1'b0;
    l1 = -1;
    l8 = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (s1_out_valid && l1 < 0) l1 = i;
      if (s8_out_valid && l8 < 0) l8 = i;
    end
    check("d1_latency", l1, 8);
    check("d8_latency", l8, 1);
    check("d1_sum", s1_sum, s_exp[7:0]);
    check("d1_cout", s1_cout, s_exp[8]);
    check("d8_sum", s8_sum, s_exp[7:0]);
    check("d8_cout", s8_cout, s_exp[8]);
    s_out_ready = 1'b1;
    step();
    s_out_ready = 1'b0;
    check("d1_release", s1_out_valid, 1'b0);
    check("d8_release", s8_out_valid, 1'b0);

    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Multi-cycle parametrised adder/subtractor. Processes WIDTH-bit operands DIGIT bits per clock through a small ripple-carry digit slice, with the carry held in a register between cycles.
- Trades latency for area against the fully unrolled ripple-carry adder.
- Sits in the datapath/ALU area behind a valid/ready handshake on both input and output.

Parameters:
- WIDTH, 32, operand and result width in bits.
- DIGIT, 8, bits added per cycle. WIDTH % DIGIT must be 0, otherwise elaboration fails. DIGIT = WIDTH gives single-cycle compute.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in; ignored when sub=1
- sub  input  1  0: a+b+cin; 1: a-b (a + ~b + 1)
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out; for sub, 1 = no borrow
- ovf  output  1  signed overflow (only with DIGIT_SERIAL_ADDER_FLAGS_EN)
- zero  output  1  sum == 0 (only with DIGIT_SERIAL_ADDER_FLAGS_EN)

Behaviour:
- Single clock clk; reset rst_n is synchronous and active-low. All state changes on the rising edge of clk.
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0.
  - sum, cout, ovf, zero, digit counter and internal operand registers all 0.
- Reset mid-operation aborts the transaction with no output produced. The first cycle after rst_n returns high is IDLE.
- FSM states: IDLE, CALC, DONE.
  - IDLE: in_ready = 1. On in_valid & in_ready:
    - latch a;
    - latch b ^ {WIDTH{sub}};
    - carry register <= sub ? 1 : cin;
    - counter <= 0;
    - go to CALC.
  - CALC: in_ready = 0. Each cycle the digit slice adds digit [counter*DIGIT +: DIGIT] of both operand registers plus the carry register:
    - result digit written to sum [counter*DIGIT +: DIGIT];
    - carry register updated;
    - counter increments.
    - On the last digit (counter == WIDTH/DIGIT - 1): cout <= slice carry out, flags computed, go to DONE.
  - DONE: out_valid = 1; sum, cout and flags stable. On out_ready, go to IDLE and drop out_valid.
- Latency:
  - out_valid asserts exactly WIDTH/DIGIT cycles after the accepting edge (4 for the defaults).
  - Minimum initiation interval is WIDTH/DIGIT + 2 cycles.
- Backpressure: the result holds indefinitely in DONE. in_valid is ignored while in CALC or DONE; the input is not accepted and not buffered.
- Arithmetic: modulo 2^WIDTH. No sign extension inside the block.
- sum is undefined-free: unprocessed digits keep their previous value during CALC. Consumers sample sum only when out_valid = 1.
- Handshake rules:
  - a, b, cin and sub are sampled only at the accepting edge; changes after acceptance have no effect.
  - in_valid may drop without acceptance.

Optional Feature:
- Macro: DIGIT_SERIAL_ADDER_FLAGS_EN.
- Defined:
  - ports ovf and zero exist;
  - ovf = carry into bit WIDTH-1 XOR cout, taken from the last digit slice;
  - zero = (final sum == 0);
  - both are registered with cout and valid in DONE.
- Undefined: ports ovf and zero and their logic are absent; the rest of the behaviour is unchanged.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, CALC, DONE);
  - localparam NUM_DIGITS = WIDTH/DIGIT;
  - counter width $clog2(NUM_DIGITS) with a minimum of 1.
- Sub-module rca_digit, parametrised on DIGIT:
  - combinational ripple chain of full_adder cells;
  - outputs the digit sum, carry out, and carry into its MSB (used for ovf).
- Top module holds the FSM, counter, operand/result registers and flags.

Test Plan:
- Reset: accept a=1, b=2, then drive rst_n=0 for 2 cycles during CALC -> out_valid=0, sum=0, in_ready=1 the cycle after release; no result ever appears for that transaction.
- Carry ripple across digits: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> out_valid 4 cycles after accept; sum=0x00000000, cout=1, zero=1, ovf=0.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001 -> sum=0x80000000, cout=0, ovf=1, zero=0.
- Subtract with borrow: sub=1, cin=1 (ignored), a=5, b=7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid while in_valid=1 with new operands -> sum/cout stable, in_ready=0, no acceptance. On out_ready=1, return to IDLE, and the new operands are accepted the next cycle.
- Parameter corner WIDTH=8, DIGIT=1: a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, out_valid 8 cycles after accept. Also WIDTH=8, DIGIT=8: same operands give the same result with a 1-cycle latency.
